// File: rtl/ysyx_23060332_exu_mc_pkg.sv
// Shared definitions for the multi-cycle execute unit: FSM states, RV opcodes,
// func3 codes for loads/stores/branches, and byte size masks.
package ysyx_23060332_exu_mc_pkg;

  typedef enum logic [2:0] {StIdle, StExec, StMreq, StMwait, StDone} exu_state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sltu   = 3'b011;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;

  localparam logic [2:0] F3Sb = 3'b000;
  localparam logic [2:0] F3Sh = 3'b001;
  localparam logic [2:0] F3Sw = 3'b010;
  localparam logic [2:0] F3Sd = 3'b011;

  localparam logic [7:0] SizeMaskB = 8'h01;
  localparam logic [7:0] SizeMaskH = 8'h03;
  localparam logic [7:0] SizeMaskW = 8'h0F;
  localparam logic [7:0] SizeMaskD = 8'hFF;

  // Byte strobe pattern for an access size encoded as func3[1:0].
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = SizeMaskB;
      2'd1:    m = SizeMaskH;
      2'd2:    m = SizeMaskW;
      default: m = SizeMaskD;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic load_ok(input logic [2:0] f3, input logic rv64);
    logic ok;
    case (f3)
      F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu: ok = 1'b1;
      F3Ld, F3Lwu:                    ok = rv64;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic store_ok(input logic [2:0] f3, input logic rv64);
    logic ok;
    case (f3)
      F3Sb, F3Sh, F3Sw: ok = 1'b1;
      F3Sd:             ok = rv64;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_23060332_exu_mc_if.sv
// Handshake/bus bundle between IDU, EXU, memory and WBU/PC side.
// Optional macro YSYX_23060332_EXU_MISALIGN_EN adds the misalign flag.
interface ysyx_23060332_exu_mc_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned INST_W     = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       op1;
  logic [XLEN-1:0]       op2;
  logic [XLEN-1:0]       op1_jump;
  logic [XLEN-1:0]       op2_jump;
  logic [XLEN-1:0]       rs2_data;
  logic                  reg_wen_i;
  logic [REG_ADDR_W-1:0] waddr_i;
  logic [INST_W-1:0]     inst_i;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_wen;
  logic [XLEN-1:0]       mem_req_addr;
  logic [XLEN-1:0]       mem_req_wdata;
  logic [XLEN/8-1:0]     mem_req_wmask;
  logic                  mem_rsp_valid;
  logic [XLEN-1:0]       mem_rsp_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic                  jump_en;
  logic [XLEN-1:0]       jump_addr;
  logic                  reg_wen_o;
  logic [REG_ADDR_W-1:0] waddr_o;
  logic [XLEN-1:0]       wdata;
`ifdef YSYX_23060332_EXU_MISALIGN_EN
  logic                  misalign;
`endif

  // EXU side
  modport master (
`ifdef YSYX_23060332_EXU_MISALIGN_EN
    output misalign,
`endif
    input  in_valid, op1, op2, op1_jump, op2_jump, rs2_data, reg_wen_i, waddr_i, inst_i,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    output in_ready, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output out_valid, jump_en, jump_addr, reg_wen_o, waddr_o, wdata
  );

  // Environment side (IDU, memory, WBU)
  modport slave (
`ifdef YSYX_23060332_EXU_MISALIGN_EN
    input  misalign,
`endif
    output in_valid, op1, op2, op1_jump, op2_jump, rs2_data, reg_wen_i, waddr_i, inst_i,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  out_valid, jump_en, jump_addr, reg_wen_o, waddr_o, wdata
  );
endinterface

// File: rtl/ysyx_23060332_lsu_align.sv
// Combinational lane alignment: store data/strobe shifting and load
// byte extraction with sign/zero extension.
module ysyx_23060332_lsu_align
  import ysyx_23060332_exu_mc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  localparam int unsigned OffW  = $clog2(XLEN / 8),
  localparam int unsigned MaskW = XLEN / 8
) (
  input  logic [2:0]       func3_i,
  input  logic [OffW-1:0]  offset_i,
  input  logic [XLEN-1:0]  store_data_i,
  input  logic [XLEN-1:0]  load_rdata_i,
  output logic [XLEN-1:0]  store_data_o,
  output logic [MaskW-1:0] store_mask_o,
  output logic [XLEN-1:0]  load_data_o
);

  logic [MaskW-1:0] base_mask;
  logic [OffW+2:0]  bit_shift;
  logic [XLEN-1:0]  lane;

  // Store: shifting inside MaskW bits drops strobes that fall past the lane.
  always_comb begin
    bit_shift    = {offset_i, 3'b000};
    base_mask    = MaskW'(size_mask(func3_i[1:0]));
    store_mask_o = base_mask << offset_i;
    store_data_o = store_data_i << bit_shift;
  end

  // Load: bring the addressed byte to bit 0, then extend per func3.
  always_comb begin
    lane = load_rdata_i >> bit_shift;
    case (func3_i)
      F3Lb:    load_data_o = XLEN'($signed(lane[7:0]));
      F3Lh:    load_data_o = XLEN'($signed(lane[15:0]));
      F3Lw:    load_data_o = XLEN'($signed(lane[31:0]));
      F3Lbu:   load_data_o = XLEN'(lane[7:0]);
      F3Lhu:   load_data_o = XLEN'(lane[15:0]);
      F3Lwu:   load_data_o = XLEN'(lane[31:0]);
      default: load_data_o = lane;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_exu_mc.sv
// Multi-cycle execute unit: IDLE -> EXEC -> (MREQ -> MWAIT ->) DONE.
// Optional macro YSYX_23060332_EXU_MISALIGN_EN traps misaligned loads/stores.
module ysyx_23060332_exu_mc
  import ysyx_23060332_exu_mc_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned INST_W     = 32
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_23060332_exu_mc_if.master bus
);

  localparam int unsigned OffW  = $clog2(XLEN / 8);
  localparam int unsigned MaskW = XLEN / 8;
  localparam logic        Rv64  = (XLEN == 64);

  exu_state_e            state_q;
  logic [XLEN-1:0]       op1_q, op2_q, op1j_q, op2j_q, rs2_q;
  logic                  wen_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [6:0]            opcode_q;
  logic [2:0]            f3_q;
  logic                  b30_q;

  logic                  in_ready_q, out_valid_q, jump_en_q, reg_wen_o_q;
  logic [XLEN-1:0]       jump_addr_q, wdata_q;
  logic [REG_ADDR_W-1:0] waddr_o_q;
  logic                  req_valid_q, req_wen_q;
  logic [XLEN-1:0]       req_addr_q, req_wdata_q;
  logic [MaskW-1:0]      req_wmask_q;
`ifdef YSYX_23060332_EXU_MISALIGN_EN
  logic                  misalign_q;
  logic                  ex_misalign;
`endif

  logic [XLEN-1:0]  sum, jsum, ex_wdata, ex_jump_addr;
  logic             ex_wen, ex_jump_en, ex_mem, ex_store, taken, br_ok;
  logic [OffW-1:0]  lsu_off;
  logic [XLEN-1:0]  st_wdata, ld_data;
  logic [MaskW-1:0] st_wmask;

  // Offset comes from the fresh sum in EXEC and the held request address later.
  assign lsu_off = (state_q == StExec) ? sum[OffW-1:0] : req_addr_q[OffW-1:0];

  ysyx_23060332_lsu_align #(
    .XLEN (XLEN)
  ) u_lsu_align (
    .func3_i      (f3_q),
    .offset_i     (lsu_off),
    .store_data_i (rs2_q),
    .load_rdata_i (bus.mem_rsp_rdata),
    .store_data_o (st_wdata),
    .store_mask_o (st_wmask),
    .load_data_o  (ld_data)
  );

  // Branch condition from the latched operands.
  always_comb begin
    br_ok = 1'b1;
    case (f3_q)
      F3Beq:   taken = (op1_q == op2_q);
      F3Bne:   taken = (op1_q != op2_q);
      F3Blt:   taken = ($signed(op1_q) < $signed(op2_q));
      F3Bge:   taken = ($signed(op1_q) >= $signed(op2_q));
      F3Bltu:  taken = (op1_q < op2_q);
      F3Bgeu:  taken = (op1_q >= op2_q);
      default: begin
        taken = 1'b0;
        br_ok = 1'b0;
      end
    endcase
  end

  // EXEC decode; defaults describe an unknown instruction.
  always_comb begin
    sum          = op1_q + op2_q;
    jsum         = op1j_q + op2j_q;
    ex_wdata     = '0;
    ex_wen       = wen_q;
    ex_jump_en   = 1'b0;
    ex_jump_addr = '0;
    ex_mem       = 1'b0;
    ex_store     = 1'b0;
`ifdef YSYX_23060332_EXU_MISALIGN_EN
    ex_misalign  = 1'b0;
`endif
    case (opcode_q)
      OpLui, OpAuipc: ex_wdata = sum;
      OpImm: begin
        if (f3_q == F3AddSub)    ex_wdata = sum;
        else if (f3_q == F3Sltu) ex_wdata = XLEN'(op1_q < op2_q);
      end
      OpReg: begin
        if (f3_q == F3AddSub) ex_wdata = b30_q ? (op1_q - op2_q) : sum;
      end
      OpJal, OpJalr: begin
        ex_wdata     = sum;
        ex_wen       = 1'b1;
        ex_jump_en   = 1'b1;
        ex_jump_addr = (opcode_q == OpJalr) ? {jsum[XLEN-1:1], 1'b0} : jsum;
      end
      OpBranch: begin
        if (br_ok) begin
          ex_wen       = 1'b0;
          ex_jump_en   = taken;
          ex_jump_addr = taken ? jsum : '0;
        end
      end
      OpLoad, OpStore: begin
        ex_store = (opcode_q == OpStore);
        if (ex_store ? store_ok(f3_q, Rv64) : load_ok(f3_q, Rv64)) begin
`ifdef YSYX_23060332_EXU_MISALIGN_EN
          if (|(sum[2:0] & align_mask(f3_q[1:0]))) begin
            ex_misalign = 1'b1;
            ex_wen      = 1'b0;
          end else begin
            ex_mem = 1'b1;
          end
`else
          ex_mem = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      op1j_q      <= '0;
      op2j_q      <= '0;
      rs2_q       <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      opcode_q    <= '0;
      f3_q        <= '0;
      b30_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
      reg_wen_o_q <= 1'b0;
      waddr_o_q   <= '0;
      wdata_q     <= '0;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
`ifdef YSYX_23060332_EXU_MISALIGN_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            op1_q      <= bus.op1;
            op2_q      <= bus.op2;
            op1j_q     <= bus.op1_jump;
            op2j_q     <= bus.op2_jump;
            rs2_q      <= bus.rs2_data;
            wen_q      <= bus.reg_wen_i;
            waddr_q    <= bus.waddr_i;
            opcode_q   <= bus.inst_i[6:0];
            f3_q       <= bus.inst_i[14:12];
            b30_q      <= bus.inst_i[30];
            in_ready_q <= 1'b0;
            state_q    <= StExec;
          end
        end
        StExec: begin
          if (ex_mem) begin
            req_valid_q <= 1'b1;
            req_wen_q   <= ex_store;
            req_addr_q  <= sum;
            req_wdata_q <= ex_store ? st_wdata : '0;
            req_wmask_q <= ex_store ? st_wmask : '0;
            state_q     <= StMreq;
          end else begin
            wdata_q     <= ex_wdata;
            reg_wen_o_q <= ex_wen;
            jump_en_q   <= ex_jump_en;
            jump_addr_q <= ex_jump_addr;
            waddr_o_q   <= waddr_q;
            out_valid_q <= 1'b1;
`ifdef YSYX_23060332_EXU_MISALIGN_EN
            misalign_q  <= ex_misalign;
`endif
            state_q     <= StDone;
          end
        end
        StMreq: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= StMwait;
          end
        end
        StMwait: begin
          if (bus.mem_rsp_valid) begin
            wdata_q     <= req_wen_q ? '0 : ld_data;
            reg_wen_o_q <= req_wen_q ? 1'b0 : wen_q;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
            waddr_o_q   <= waddr_q;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            jump_en_q   <= 1'b0;
`ifdef YSYX_23060332_EXU_MISALIGN_EN
            misalign_q  <= 1'b0;
`endif
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_wen   = req_wen_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.jump_en       = jump_en_q;
  assign bus.jump_addr     = jump_addr_q;
  assign bus.reg_wen_o     = reg_wen_o_q;
  assign bus.waddr_o       = waddr_o_q;
  assign bus.wdata         = wdata_q;
`ifdef YSYX_23060332_EXU_MISALIGN_EN
  assign bus.misalign      = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_23060332_exu_mc.sv
// Directed bench for the multi-cycle execute unit (XLEN=32).
module tb_ysyx_23060332_exu_mc;

  localparam logic [6:0] OLUI = 7'b0110111, OAUI = 7'b0010111, OJAL = 7'b1101111;
  localparam logic [6:0] OJALR = 7'b1100111, OBR = 7'b1100011, OLD = 7'b0000011;
  localparam logic [6:0] OST = 7'b0100011, OIMM = 7'b0010011, OREG = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060332_exu_mc_if #(.XLEN(32), .REG_ADDR_W(5), .INST_W(32)) bus ();

  ysyx_23060332_exu_mc #(
    .XLEN       (32),
    .REG_ADDR_W (5),
    .INST_W     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] op1, op2, op1j, op2j;
    logic        wen_i;
    logic [31:0] e_wdata;
    logic        e_wen;
    logic        e_je;
    logic [31:0] e_ja;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic b30);
    return {1'b0, b30, 15'b0, f3, 5'b0, op};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and return just after the accepting edge (EXU in EXEC).
  task automatic issue(input logic [31:0] inst, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [31:0] op1j, input logic [31:0] op2j,
                       input logic [31:0] rs2, input logic wen, input logic [4:0] waddr);
    int cyc;
    bus.inst_i = inst; bus.op1 = op1; bus.op2 = op2; bus.op1_jump = op1j;
    bus.op2_jump = op2j; bus.rs2_data = rs2; bus.reg_wen_i = wen; bus.waddr_i = waddr;
    bus.in_valid = 1'b1;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic [4:0] waddr);
    issue(v.inst, v.op1, v.op2, v.op1j, v.op2j, 32'h0, v.wen_i, waddr);
    check({v.name, "_exec_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({v.name, "_exec_in_ready"}, 64'(bus.in_ready), 64'd0);
    tick();
    check({v.name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({v.name, "_no_mem"}, 64'(bus.mem_req_valid), 64'd0);
    check({v.name, "_wdata"}, 64'(bus.wdata), 64'(v.e_wdata));
    check({v.name, "_reg_wen"}, 64'(bus.reg_wen_o), 64'(v.e_wen));
    check({v.name, "_jump_en"}, 64'(bus.jump_en), 64'(v.e_je));
    check({v.name, "_jump_addr"}, 64'(bus.jump_addr), 64'(v.e_ja));
    check({v.name, "_waddr"}, 64'(bus.waddr_o), 64'(waddr));
    tick();
    check({v.name, "_valid_clr"}, 64'(bus.out_valid), 64'd0);
    check({v.name, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] lo,
                          input logic [31:0] rs2, input int delay,
                          input logic [3:0] e_mask, input logic [31:0] e_wdata);
    bus.mem_req_ready = 1'b0;
    issue(mk(OST, f3, 1'b0), 32'h8000_0000, lo, 32'h0, 32'h0, rs2, 1'b1, 5'd9);
    tick();
    for (int i = 0; i <= delay; i++) begin
      check({name, "_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
      check({name, "_req_addr"}, 64'(bus.mem_req_addr), 64'(32'h8000_0000 + lo));
      check({name, "_req_wen"}, 64'(bus.mem_req_wen), 64'd1);
      check({name, "_req_wmask"}, 64'(bus.mem_req_wmask), 64'(e_mask));
      check({name, "_req_wdata"}, 64'(bus.mem_req_wdata), 64'(e_wdata));
      if (i == delay) bus.mem_req_ready = 1'b1;
      tick();
    end
    bus.mem_req_ready = 1'b0;
    check({name, "_req_dropped"}, 64'(bus.mem_req_valid), 64'd0);
    check({name, "_wait_no_out"}, 64'(bus.out_valid), 64'd0);
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_wdata"}, 64'(bus.wdata), 64'd0);
    check({name, "_reg_wen"}, 64'(bus.reg_wen_o), 64'd0);
    tick();
  endtask

  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] lo,
                         input logic [31:0] rdata, input int delay, input logic [31:0] e_wdata);
    issue(mk(OLD, f3, 1'b0), 32'h8000_0000, lo, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7);
    // Early responses (EXEC and handshake cycle) must be ignored.
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h5A5A_5A5A;
    tick();
    check({name, "_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({name, "_req_wen"}, 64'(bus.mem_req_wen), 64'd0);
    check({name, "_req_addr"}, 64'(bus.mem_req_addr), 64'(32'h8000_0000 + lo));
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    check({name, "_req_dropped"}, 64'(bus.mem_req_valid), 64'd0);
    check({name, "_early_rsp_ignored"}, 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < delay; i++) tick();
    check({name, "_still_waiting"}, 64'(bus.out_valid), 64'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = rdata;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_wdata"}, 64'(bus.wdata), 64'(e_wdata));
    check({name, "_reg_wen"}, 64'(bus.reg_wen_o), 64'd1);
    check({name, "_waddr"}, 64'(bus.waddr_o), 64'd7);
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check({name, "_req_wen"}, 64'(bus.mem_req_wen), 64'd0);
    check({name, "_req_addr"}, 64'(bus.mem_req_addr), 64'd0);
    check({name, "_req_wdata"}, 64'(bus.mem_req_wdata), 64'd0);
    check({name, "_req_wmask"}, 64'(bus.mem_req_wmask), 64'd0);
    check({name, "_jump_en"}, 64'(bus.jump_en), 64'd0);
    check({name, "_jump_addr"}, 64'(bus.jump_addr), 64'd0);
    check({name, "_reg_wen"}, 64'(bus.reg_wen_o), 64'd0);
    check({name, "_waddr"}, 64'(bus.waddr_o), 64'd0);
    check({name, "_wdata"}, 64'(bus.wdata), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.op1_jump = '0; bus.op2_jump = '0;
    bus.rs2_data = '0; bus.reg_wen_i = 1'b0; bus.waddr_i = '0; bus.inst_i = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    bus.out_ready = 1'b1;

    vt.push_back('{"addi", mk(OIMM, 3'b000, 1'b0), 32'd5, 32'd7, 32'h0, 32'h0, 1'b1,
                   32'd12, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"add_wrap", mk(OREG, 3'b000, 1'b0), 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0,
                   1'b1, 32'd1, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"sub", mk(OREG, 3'b000, 1'b1), 32'd5, 32'd7, 32'h0, 32'h0, 1'b1,
                   32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"sltiu_t", mk(OIMM, 3'b011, 1'b0), 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0,
                   1'b1, 32'd1, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"sltiu_f", mk(OIMM, 3'b011, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0,
                   1'b1, 32'd0, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"lui", mk(OLUI, 3'b000, 1'b0), 32'h0, 32'h1234_5000, 32'h0, 32'h0, 1'b1,
                   32'h1234_5000, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"auipc", mk(OAUI, 3'b000, 1'b0), 32'h8000_0000, 32'h1000, 32'h0, 32'h0,
                   1'b1, 32'h8000_1000, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"jal", mk(OJAL, 3'b000, 1'b0), 32'h8000_0000, 32'd4, 32'h8000_0000,
                   32'h100, 1'b0, 32'h8000_0004, 1'b1, 1'b1, 32'h8000_0100});
    vt.push_back('{"bne_t", mk(OBR, 3'b001, 1'b0), 32'd1, 32'd2, 32'h8000_0000, 32'h10, 1'b0,
                   32'h0, 1'b0, 1'b1, 32'h8000_0010});
    vt.push_back('{"beq_nt", mk(OBR, 3'b000, 1'b0), 32'd1, 32'd2, 32'h8000_0000, 32'h10, 1'b0,
                   32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{"blt_t", mk(OBR, 3'b100, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                   32'h20, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0020});
    vt.push_back('{"bltu_nt", mk(OBR, 3'b110, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                   32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{"bge_nt", mk(OBR, 3'b101, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                   32'h30, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{"bgeu_t", mk(OBR, 3'b111, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                   32'h30, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0030});
    vt.push_back('{"bad_opcode", mk(7'b1111111, 3'b000, 1'b0), 32'd3, 32'd4, 32'h0, 32'h0,
                   1'b1, 32'h0, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"bad_branch_f3", mk(OBR, 3'b010, 1'b0), 32'd1, 32'd1, 32'h8000_0000,
                   32'h10, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0});
    vt.push_back('{"bad_load_f3", mk(OLD, 3'b111, 1'b0), 32'h8000_0000, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h0, 1'b1, 1'b0, 32'h0});

    // Reset state
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    foreach (vt[i]) run_vec(vt[i], 5'(i + 1));

    // Stores with delayed ready
    do_store("sb_off3", 3'b000, 32'd3, 32'h0000_00AB, 3, 4'b1000, 32'hAB00_0000);
    do_store("sh_off2", 3'b001, 32'd2, 32'h0000_1234, 0, 4'b1100, 32'h1234_0000);
    do_store("sw_off0", 3'b010, 32'd0, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);
`ifndef YSYX_23060332_EXU_MISALIGN_EN
    do_store("sw_misal", 3'b010, 32'd1, 32'h1122_3344, 0, 4'b1110, 32'h2233_4400);
`endif

    // Loads with delayed response
    do_load("lb", 3'b000, 32'd2, 32'h0080_0000, 5, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'd2, 32'h0080_0000, 5, 32'h0000_0080);
    do_load("lh", 3'b001, 32'd2, 32'h8001_0000, 1, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'd2, 32'h8001_0000, 0, 32'h0000_8001);
    do_load("lw", 3'b010, 32'd0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);

    // JALR with consumer stalling for three cycles
    bus.out_ready = 1'b0;
    issue(mk(OJALR, 3'b000, 1'b0), 32'h8000_0000, 32'd4, 32'h8000_0005, 32'h0, 32'h0, 1'b1,
          5'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("jalr_stall_valid", 64'(bus.out_valid), 64'd1);
      check("jalr_stall_jump_en", 64'(bus.jump_en), 64'd1);
      check("jalr_stall_jump_addr", 64'(bus.jump_addr), 64'h8000_0004);
      check("jalr_stall_wdata", 64'(bus.wdata), 64'h8000_0004);
      check("jalr_stall_reg_wen", 64'(bus.reg_wen_o), 64'd1);
      check("jalr_stall_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    check("jalr_pre_hs_valid", 64'(bus.out_valid), 64'd1);
    tick();
    check("jalr_post_valid", 64'(bus.out_valid), 64'd0);
    check("jalr_post_jump_en", 64'(bus.jump_en), 64'd0);
    check("jalr_post_in_ready", 64'(bus.in_ready), 64'd1);
    check("jalr_keep_jump_addr", 64'(bus.jump_addr), 64'h8000_0004);
    check("jalr_keep_wdata", 64'(bus.wdata), 64'h8000_0004);

    // Reset while waiting for a load response
    issue(mk(OLD, 3'b010, 1'b0), 32'h8000_0000, 32'h4, 32'h0, 32'h0, 32'h0, 1'b1, 5'd3);
    bus.mem_req_ready = 1'b1;
    tick();
    check("rst_mwait_req_valid", 64'(bus.mem_req_valid), 64'd1);
    tick();
    bus.mem_req_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mwait");
    tick();
    rst = 1'b0;

    // Reset while a request is pending abandons it at once
    issue(mk(OST, 3'b010, 1'b0), 32'h8000_0000, 32'h8, 32'h0, 32'h0, 32'h55AA_55AA, 1'b0,
          5'd4);
    tick();
    check("rst_mreq_req_valid", 64'(bus.mem_req_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mreq");
    tick();
    rst = 1'b0;
    run_vec(vt[0], 5'd30);

`ifdef YSYX_23060332_EXU_MISALIGN_EN
    issue(mk(OLD, 3'b010, 1'b0), 32'h0, 32'h2, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5);
    tick();
    check("misal_out_valid", 64'(bus.out_valid), 64'd1);
    check("misal_flag", 64'(bus.misalign), 64'd1);
    check("misal_no_req", 64'(bus.mem_req_valid), 64'd0);
    check("misal_reg_wen", 64'(bus.reg_wen_o), 64'd0);
    tick();
    check("misal_flag_clr", 64'(bus.misalign), 64'd0);
    check("misal_valid_clr", 64'(bus.out_valid), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
